noc_snn_engine: RTL and testbench
=================================

# noc_snn_engine

Clocked spiking-convolution engine for the SNN accelerator top level. It loads a 5×5 unsigned filter and two 32×32 binary input spike maps (timesteps 1 and 2) over valid/ready write ports. It computes a valid-mode convolution into 28×28 integrate-and-fire membrane potentials and streams one output spike per pixel per timestep to the result checker. All host-facing transfers are valid/ready handshakes.

## Interface
- DATA_W, 8, filter weight width (unsigned)
- ADDR_W, 12, address width on all address ports
- OUT_W, 13, output data and membrane potential width
- F_DIM, 5, filter side
- I_DIM, 32, ifmap side; output side R_DIM = I_DIM−F_DIM+1 = 28
- THRESHOLD, 64, firing threshold

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- load_start_valid / load_start_ready  in/out  1  load-phase start token
- filter_valid / filter_ready  in/out  1  filter write handshake
- filter_addr  in  ADDR_W  tap index 0..24, row-major
- filter_data  in  DATA_W  weight
- ifmap_valid / ifmap_ready  in/out  1  ifmap write handshake
- ifmap_ts  in  2  timestep, 1 or 2
- ifmap_addr  in  ADDR_W  pixel index 0..1023, row-major
- ifmap_data  in  1  input spike
- load_done_valid / load_done_ready  in/out  1  end-of-load token
- start_valid / start_ready  out/in  1  results-begin token, value 1
- hdr_valid / hdr_ready  out/in  1  per-timestep header handshake
- hdr_ts  out  2  timestep of following block
- hdr_layer  out  2  layer index, constant 1
- out_valid / out_ready  out/in  1  spike result handshake
- out_addr  out  ADDR_W  output pixel index r*28+c
- out_data  out  OUT_W  spike, 0 or 1, zero-extended
- done_valid / done_ready  out/in  1  completion token, value 1

## Operation
- A transfer occurs on a rising edge where valid && ready are both high. Senders hold data stable while valid is high.
- States: IDLE → LOAD → START → HDR → MAC → FIRE → EMIT → (MAC for the next pixel | HDR for ts 2 | DONE) → IDLE.
- IDLE:
  - load_start_ready=1.
  - Load-start handshake clears the filter memory, both ifmap planes, and all 784 potentials, then enters LOAD.
- LOAD:
  - filter_ready=1, ifmap_ready=1, load_done_ready=1.
  - A filter write stores filter_data at filter_addr.
  - An ifmap write stores ifmap_data in plane ifmap_ts at ifmap_addr.
  - Writes with filter_addr≥25, ifmap_addr≥1024, or ifmap_ts∉{1,2} are accepted and discarded.
  - A load-done handshake moves to START. Missing entries keep their cleared value of 0.
- START: start_valid=1 until handshake.
- HDR: hdr_valid=1 with hdr_ts = current timestep (1, then 2) and hdr_layer=1.
- MAC:
  - Pixel (r,c) row-major. One tap per cycle, 25 cycles.
  - acc += filter[i*5+j] when ifmap[ts][(r+i)*32+(c+j)]=1.
  - acc is OUT_W bits, cleared at pixel start. Maximum is 25×255=6375, so there is no overflow.
- FIRE:
  - v = pot[r*28+c] + acc, saturating at 2^OUT_W−1.
  - If v ≥ THRESHOLD, spike=1 and the reset rule in Configuration applies. Otherwise spike=0 and pot=v.
- EMIT:
  - out_valid=1, out_addr=r*28+c, out_data=spike.
  - Potentials persist from timestep 1 to timestep 2.
- DONE: done_valid=1. Handshake returns to IDLE.
- All ready signals not listed for a state are 0. Valids and data outside their state are 0.

## Timing
- Reset values: every *_ready and *_valid output is 0, hdr_ts=0, hdr_layer=0, out_addr=0, out_data=0. The state is IDLE, where load_start_ready=1 from the first cycle after reset.
- rst during any state returns to IDLE next cycle. Memories are not cleared by rst; they are cleared by the next load-start.
- Latencies:
  - start_valid rises the cycle after the load-done handshake.
  - hdr_valid rises the cycle after the start handshake.
  - The first out_valid comes 26 cycles after the header handshake (25 MAC + 1 FIRE).
  - Each subsequent pixel takes 26 cycles after the previous out handshake.
- Backpressure: with out_ready low, out_valid, out_addr, and out_data hold indefinitely.
- The result stream per run is start, header(ts1), 784 spikes, header(ts2), 784 spikes, done.

## Configuration
- SNN_SOFT_RESET_EN defined: on a spike, pot = v − THRESHOLD (residual kept).
- SNN_SOFT_RESET_EN undefined: on a spike, pot = 0 (hard reset).

## Test plan
- Filter all 3, both ifmaps all 1: v=75 per pixel in ts1, so all 784 ts1 spikes are 1. In ts2, hard reset gives v=75 and soft reset gives v=86; all spikes are 1 in both builds.
- Filter all 2, both ifmaps all 1: ts1 v=50, so all ts1 spikes are 0. ts2 v=100, so all ts2 spikes are 1.
- filter[0]=64 with all other taps 0, and ifmap1 containing a single 1 at addr 0: ts1 out_addr 0 is 1 and the other 783 are 0. ifmap2 all 0 gives all ts2 spikes 0 (hard reset) and potential 0.
- Stall out_ready low for 50 cycles mid-stream: out_addr and out_data are held, with no lost or duplicated address across 0..783.
- Out-of-range writes (filter_addr=30, ifmap_ts=3): both are accepted and ignored, and results match the in-range-only load.
- Assert rst during MAC: the next cycle is IDLE with all outputs at reset values. A fresh load then reproduces the expected results.

Source files
------------

// File: rtl/noc_snn_engine.sv
// rtl/noc_snn_engine.sv - spiking 5x5 valid-mode convolution engine with integrate-and-fire result stream
// Purpose: loads a filter and two binary ifmap planes, convolves each timestep into
//   R_DIM x R_DIM integrate-and-fire potentials and streams one spike per pixel per timestep.
// Ports:
//   clk, rst                               clock, synchronous active-high reset
//   load_start_*, load_done_*              load-phase start / end tokens (input valid, output ready)
//   filter_*, ifmap_*                      memory write handshakes, accepted only in LOAD
//   start_*, hdr_*, out_*, done_*          result stream (output valid, input ready)
// Build option: SNN_SOFT_RESET_EN keeps the residual (v - THRESHOLD) on a spike;
//   without it a spike hard-resets the potential to 0.
module noc_snn_engine #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 12,
    parameter int OUT_W     = 13,
    parameter int F_DIM     = 5,
    parameter int I_DIM     = 32,
    parameter int THRESHOLD = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start_valid,
    output logic              load_start_ready,
    input  logic              filter_valid,
    output logic              filter_ready,
    input  logic [ADDR_W-1:0] filter_addr,
    input  logic [DATA_W-1:0] filter_data,
    input  logic              ifmap_valid,
    output logic              ifmap_ready,
    input  logic [1:0]        ifmap_ts,
    input  logic [ADDR_W-1:0] ifmap_addr,
    input  logic              ifmap_data,
    input  logic              load_done_valid,
    output logic              load_done_ready,
    output logic              start_valid,
    input  logic              start_ready,
    output logic              hdr_valid,
    input  logic              hdr_ready,
    output logic [1:0]        hdr_ts,
    output logic [1:0]        hdr_layer,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [OUT_W-1:0]  out_data,
    output logic              done_valid,
    input  logic              done_ready
);
    localparam int R_DIM = I_DIM - F_DIM + 1;
    localparam int N_TAP = F_DIM * F_DIM;
    localparam int N_IPX = I_DIM * I_DIM;
    localparam int N_OPX = R_DIM * R_DIM;
    localparam int TAP_W = $clog2(N_TAP);
    localparam int IPX_W = $clog2(N_IPX);
    localparam int OPX_W = $clog2(N_OPX);
    localparam int RC_W  = $clog2(I_DIM);
    localparam int FD_W  = $clog2(F_DIM);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_HDR, S_MAC, S_FIRE, S_EMIT, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              ts_q, ts_d;          // 0 = timestep 1, 1 = timestep 2
    logic [RC_W-1:0]   r_q, r_d, c_q, c_d;
    logic [FD_W-1:0]   ti_q, ti_d, tj_q, tj_d;
    logic [OPX_W-1:0]  pix_q, pix_d;        // r*R_DIM+c, kept as a counter
    logic [OUT_W-1:0]  acc_q, acc_d;
    logic              spike_q, spike_d;

    logic [DATA_W-1:0] filt_mem [N_TAP];
    logic [N_IPX-1:0]  ifm_mem  [2];
    logic [OUT_W-1:0]  pot_mem  [N_OPX];

    logic              mem_clear, filt_we, ifm_we, pot_we;
    logic [OUT_W-1:0]  pot_wdata;
    logic [TAP_W-1:0]  tap_idx;
    logic [IPX_W-1:0]  ifm_idx;
    logic [OUT_W:0]    v_sum;
    logic [OUT_W-1:0]  v_sat;

    always_comb begin
        state_d = state_q;
        ts_d    = ts_q;
        r_d     = r_q;
        c_d     = c_q;
        ti_d    = ti_q;
        tj_d    = tj_q;
        pix_d   = pix_q;
        acc_d   = acc_q;
        spike_d = spike_q;

        mem_clear = 1'b0;
        filt_we   = 1'b0;
        ifm_we    = 1'b0;
        pot_we    = 1'b0;
        pot_wdata = '0;

        load_start_ready = 1'b0;
        filter_ready     = 1'b0;
        ifmap_ready      = 1'b0;
        load_done_ready  = 1'b0;
        start_valid      = 1'b0;
        hdr_valid        = 1'b0;
        hdr_ts           = 2'd0;
        hdr_layer        = 2'd0;
        out_valid        = 1'b0;
        out_addr         = '0;
        out_data         = '0;
        done_valid       = 1'b0;

        tap_idx = TAP_W'(int'(ti_q) * F_DIM + int'(tj_q));
        ifm_idx = IPX_W'((int'(r_q) + int'(ti_q)) * I_DIM + int'(c_q) + int'(tj_q));
        v_sum   = {1'b0, pot_mem[pix_q]} + {1'b0, acc_q};
        v_sat   = v_sum[OUT_W] ? '1 : v_sum[OUT_W-1:0];

        case (state_q)
            S_IDLE: begin
                load_start_ready = 1'b1;
                if (load_start_valid) begin
                    mem_clear = 1'b1;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                filter_ready    = 1'b1;
                ifmap_ready     = 1'b1;
                load_done_ready = 1'b1;
                // Out-of-range writes complete the handshake but never touch storage.
                filt_we = filter_valid && (filter_addr < ADDR_W'(N_TAP));
                ifm_we  = ifmap_valid && (ifmap_ts == 2'd1 || ifmap_ts == 2'd2)
                          && (ifmap_addr < ADDR_W'(N_IPX));
                if (load_done_valid) state_d = S_START;
            end
            S_START: begin
                start_valid = 1'b1;
                if (start_ready) begin
                    ts_d    = 1'b0;
                    r_d     = '0;
                    c_d     = '0;
                    pix_d   = '0;
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                hdr_valid = 1'b1;
                hdr_ts    = ts_q ? 2'd2 : 2'd1;
                hdr_layer = 2'd1;
                if (hdr_ready) begin
                    acc_d   = '0;
                    ti_d    = '0;
                    tj_d    = '0;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                if (ifm_mem[ts_q][ifm_idx]) acc_d = acc_q + OUT_W'(filt_mem[tap_idx]);
                if (tj_q == FD_W'(F_DIM - 1)) begin
                    tj_d = '0;
                    if (ti_q == FD_W'(F_DIM - 1)) state_d = S_FIRE;
                    else                          ti_d = ti_q + FD_W'(1);
                end else begin
                    tj_d = tj_q + FD_W'(1);
                end
            end
            S_FIRE: begin
                spike_d = (v_sat >= OUT_W'(THRESHOLD));
                pot_we  = 1'b1;
`ifdef SNN_SOFT_RESET_EN
                pot_wdata = spike_d ? (v_sat - OUT_W'(THRESHOLD)) : v_sat;
`else
                pot_wdata = spike_d ? '0 : v_sat;
`endif
                state_d = S_EMIT;
            end
            S_EMIT: begin
                out_valid = 1'b1;
                out_addr  = ADDR_W'(pix_q);
                out_data  = OUT_W'(spike_q);
                if (out_ready) begin
                    acc_d = '0;
                    ti_d  = '0;
                    tj_d  = '0;
                    if (pix_q == OPX_W'(N_OPX - 1)) begin
                        r_d   = '0;
                        c_d   = '0;
                        pix_d = '0;
                        if (!ts_q) begin
                            ts_d    = 1'b1;
                            state_d = S_HDR;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        pix_d = pix_q + OPX_W'(1);
                        if (c_q == RC_W'(R_DIM - 1)) begin
                            c_d = '0;
                            r_d = r_q + RC_W'(1);
                        end else begin
                            c_d = c_q + RC_W'(1);
                        end
                        state_d = S_MAC;
                    end
                end
            end
            S_DONE: begin
                done_valid = 1'b1;
                if (done_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ts_q    <= 1'b0;
            r_q     <= '0;
            c_q     <= '0;
            ti_q    <= '0;
            tj_q    <= '0;
            pix_q   <= '0;
            acc_q   <= '0;
            spike_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ts_q    <= ts_d;
            r_q     <= r_d;
            c_q     <= c_d;
            ti_q    <= ti_d;
            tj_q    <= tj_d;
            pix_q   <= pix_d;
            acc_q   <= acc_d;
            spike_q <= spike_d;
        end
    end

    // Storage is deliberately outside rst: only a load-start clears it.
    always_ff @(posedge clk) begin
        if (mem_clear) begin
            for (int k = 0; k < N_TAP; k++) filt_mem[k] <= '0;
            ifm_mem[0] <= '0;
            ifm_mem[1] <= '0;
            for (int k = 0; k < N_OPX; k++) pot_mem[k] <= '0;
        end else begin
            if (filt_we) filt_mem[TAP_W'(filter_addr)] <= filter_data;
            if (ifm_we)  ifm_mem[ifmap_ts[1]][IPX_W'(ifmap_addr)] <= ifmap_data;
            if (pot_we)  pot_mem[pix_q] <= pot_wdata;
        end
    end
endmodule

// File: tb/tb_noc_snn_engine.sv
// tb/tb_noc_snn_engine.sv - self-checking bench for noc_snn_engine
module tb_noc_snn_engine;
    localparam int AW = 12, DW = 8, OW = 13, FD = 5, TI = 12, THR = 64;
    localparam int TR = TI - FD + 1, NT = FD * FD, NI = TI * TI, NO = TR * TR;

    logic clk = 1'b0;
    logic rst;
    logic load_start_valid, load_start_ready;
    logic filter_valid, filter_ready;
    logic [AW-1:0] filter_addr;
    logic [DW-1:0] filter_data;
    logic ifmap_valid, ifmap_ready;
    logic [1:0] ifmap_ts;
    logic [AW-1:0] ifmap_addr;
    logic ifmap_data;
    logic load_done_valid, load_done_ready;
    logic start_valid, start_ready;
    logic hdr_valid, hdr_ready;
    logic [1:0] hdr_ts, hdr_layer;
    logic out_valid, out_ready;
    logic [AW-1:0] out_addr;
    logic [OW-1:0] out_data;
    logic done_valid, done_ready;

    noc_snn_engine #(.DATA_W(DW), .ADDR_W(AW), .OUT_W(OW), .F_DIM(FD), .I_DIM(TI), .THRESHOLD(THR)) dut (
        .clk(clk), .rst(rst),
        .load_start_valid(load_start_valid), .load_start_ready(load_start_ready),
        .filter_valid(filter_valid), .filter_ready(filter_ready),
        .filter_addr(filter_addr), .filter_data(filter_data),
        .ifmap_valid(ifmap_valid), .ifmap_ready(ifmap_ready),
        .ifmap_ts(ifmap_ts), .ifmap_addr(ifmap_addr), .ifmap_data(ifmap_data),
        .load_done_valid(load_done_valid), .load_done_ready(load_done_ready),
        .start_valid(start_valid), .start_ready(start_ready),
        .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_ts(hdr_ts), .hdr_layer(hdr_layer),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
        .done_valid(done_valid), .done_ready(done_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int fmode; int m1; int m2; bit oob; bit stall; int ones1; int ones2; } vec_t;
    typedef struct { int kind; int a; int d; } exp_t;   // kind: 0 start, 1 hdr, 2 out, 3 done

    vec_t vecs[6];
    exp_t sb[$];
    int   filt_b[NT];
    bit   ifm_b[2][NI];
    int   n_err = 0, n_checks = 0;
    int   hs_edge = 0;
    int   ones[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_idle_outputs();
        check("idle_load_start_ready", load_start_ready, 1);
        check("idle_filter_ready", filter_ready, 0);
        check("idle_ifmap_ready", ifmap_ready, 0);
        check("idle_load_done_ready", load_done_ready, 0);
        check("idle_start_valid", start_valid, 0);
        check("idle_hdr_valid", hdr_valid, 0);
        check("idle_hdr_ts", hdr_ts, 0);
        check("idle_hdr_layer", hdr_layer, 0);
        check("idle_out_valid", out_valid, 0);
        check("idle_out_addr", out_addr, 0);
        check("idle_out_data", out_data, 0);
        check("idle_done_valid", done_valid, 0);
    endtask

    task automatic set_patterns(input vec_t v);
        int m;
        for (int k = 0; k < NT; k++)
            filt_b[k] = (v.fmode == 0) ? 3 : (v.fmode == 1) ? 2 : ((k == 0) ? 64 : 0);
        for (int t = 0; t < 2; t++) begin
            m = (t == 0) ? v.m1 : v.m2;
            for (int k = 0; k < NI; k++) ifm_b[t][k] = (m == 0) || (m == 2 && k == 0);
        end
    endtask

    // Reference integrate-and-fire model producing the full expected result stream.
    task automatic build_expected();
        int pot[NO];
        int acc, v, spk, r, c;
        sb.delete();
        for (int p = 0; p < NO; p++) pot[p] = 0;
        sb.push_back('{0, 0, 1});
        for (int t = 0; t < 2; t++) begin
            sb.push_back('{1, t + 1, 1});
            for (int p = 0; p < NO; p++) begin
                r = p / TR;
                c = p % TR;
                acc = 0;
                for (int i = 0; i < FD; i++)
                    for (int j = 0; j < FD; j++)
                        if (ifm_b[t][(r + i) * TI + c + j]) acc += filt_b[i * FD + j];
                v = pot[p] + acc;
                if (v > (1 << OW) - 1) v = (1 << OW) - 1;
                if (v >= THR) begin
                    spk = 1;
`ifdef SNN_SOFT_RESET_EN
                    pot[p] = v - THR;
`else
                    pot[p] = 0;
`endif
                end else begin
                    spk = 0;
                    pot[p] = v;
                end
                sb.push_back('{2, p, spk});
            end
        end
        sb.push_back('{3, 0, 1});
    endtask

    task automatic do_load(input bit oob);
        @(negedge clk);
        check("load_start_ready", load_start_ready, 1);
        load_start_valid = 1'b1;
        @(negedge clk);
        load_start_valid = 1'b0;
        check("load_filter_ready", filter_ready, 1);
        check("load_ifmap_ready", ifmap_ready, 1);
        check("load_done_ready", load_done_ready, 1);
        // Only nonzero entries are written; the rest rely on the load-start clear.
        for (int k = 0; k < NT; k++) begin
            if (filt_b[k] != 0) begin
                filter_valid = 1'b1; filter_addr = AW'(k); filter_data = DW'(filt_b[k]);
                @(negedge clk);
            end
        end
        filter_valid = 1'b0;
        for (int t = 0; t < 2; t++)
            for (int k = 0; k < NI; k++)
                if (ifm_b[t][k]) begin
                    ifmap_valid = 1'b1; ifmap_ts = 2'(t + 1); ifmap_addr = AW'(k); ifmap_data = 1'b1;
                    @(negedge clk);
                end
        ifmap_valid = 1'b0;
        if (oob) begin
            filter_valid = 1'b1; filter_addr = 30; filter_data = 255; @(negedge clk);
            filter_addr = 32; @(negedge clk);
            filter_valid = 1'b0;
            ifmap_valid = 1'b1; ifmap_data = 1'b1;
            ifmap_ts = 2'd3; ifmap_addr = 0; @(negedge clk);
            ifmap_ts = 2'd0; ifmap_addr = 0; @(negedge clk);
            ifmap_ts = 2'd1; ifmap_addr = 256; @(negedge clk);
            ifmap_valid = 1'b0;
        end
        load_done_valid = 1'b1;
        @(posedge clk); #1;
        load_done_valid = 1'b0;
        hs_edge = cyc;
    endtask

    task automatic run_results(input bit stall);
        int kind, prev_kind, nout, cur_ts, lat;
        bit seen, fin, do_stall;
        exp_t e;
        prev_kind = -1; nout = 0; cur_ts = 1; seen = 0; fin = 0; do_stall = stall;
        ones[1] = 0; ones[2] = 0;
        start_ready = 1'b1; hdr_ready = 1'b1; out_ready = 1'b1; done_ready = 1'b1;
        for (int n = 0; n < 20000 && !fin; n++) begin
            @(negedge clk);
            kind = start_valid ? 0 : hdr_valid ? 1 : out_valid ? 2 : done_valid ? 3 : -1;
            if (kind >= 0 && !seen) begin
                seen = 1;
                lat = cyc - hs_edge;
                if (kind == 0 || (kind == 1 && prev_kind == 0)) check("lat_start_hdr", lat, 0);
                if (kind == 2) check("lat_out", lat, 26);
            end
            if (do_stall && kind == 2 && nout == 20 && sb.size() > 0) begin
                do_stall = 0;
                out_ready = 1'b0;
                for (int s = 0; s < 50; s++) begin
                    @(negedge clk);
                    check("stall_out_valid", out_valid, 1);
                    check("stall_out_addr", out_addr, sb[0].a);
                    check("stall_out_data", out_data, sb[0].d);
                end
                out_ready = 1'b1;
            end
            if (kind >= 0) begin
                if (sb.size() == 0) begin
                    n_checks++; n_err++;
                    $display("FAIL sb_underflow: got item kind %0d expected none", kind);
                    fin = 1;
                end else begin
                    e = sb.pop_front();
                    check("sb_kind", kind, e.kind);
                    if (e.kind == 1) begin
                        check("hdr_ts", hdr_ts, e.a);
                        check("hdr_layer", hdr_layer, e.d);
                        cur_ts = e.a;
                    end else if (e.kind == 2) begin
                        check("out_addr", out_addr, e.a);
                        check("out_data", out_data, e.d);
                        ones[cur_ts] += int'(out_data);
                        nout++;
                    end
                    hs_edge = cyc + 1;
                    seen = 0;
                    prev_kind = kind;
                    if (kind == 3) fin = 1;
                end
            end
        end
        if (!fin) begin
            n_checks++; n_err++;
            $display("FAIL run_timeout: got %0d items left expected 0", sb.size());
        end
        check("sb_left", sb.size(), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 0, 0, 1'b0, 1'b0, NO, NO};   // filter 3, ifmaps all 1
        vecs[1] = '{1, 0, 0, 1'b0, 1'b0, 0,  NO};   // filter 2, ifmaps all 1
        vecs[2] = '{2, 2, 1, 1'b0, 1'b0, 1,  0};    // tap0=64, single spike at 0, ts2 zero
        vecs[3] = '{0, 0, 0, 1'b0, 1'b1, NO, NO};   // as vec 0 with out_ready stall
        vecs[4] = '{1, 0, 0, 1'b1, 1'b0, 0,  NO};   // out-of-range filter writes
        vecs[5] = '{2, 1, 1, 1'b1, 1'b0, 0,  0};    // out-of-range ifmap writes

        rst = 1'b1;
        load_start_valid = 0; filter_valid = 0; filter_addr = 0; filter_data = 0;
        ifmap_valid = 0; ifmap_ts = 0; ifmap_addr = 0; ifmap_data = 0; load_done_valid = 0;
        start_ready = 0; hdr_ready = 0; out_ready = 0; done_ready = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_idle_outputs();

        for (int v = 0; v < 6; v++) begin
            set_patterns(vecs[v]);
            do_load(vecs[v].oob);
            build_expected();
            run_results(vecs[v].stall);
            check("ones_ts1", ones[1], vecs[v].ones1);
            check("ones_ts2", ones[2], vecs[v].ones2);
        end

        // Reset in the middle of MAC, then a fresh load must reproduce vec 0.
        set_patterns(vecs[0]);
        do_load(1'b0);
        start_ready = 1'b1; hdr_ready = 1'b1; out_ready = 1'b1; done_ready = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (hdr_valid) break;
        end
        check("rst_test_hdr_seen", hdr_valid, 1);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_outputs();
        do_load(1'b0);
        build_expected();
        run_results(1'b0);
        check("rst_ones_ts1", ones[1], vecs[0].ones1);
        check("rst_ones_ts2", ones[2], vecs[0].ones2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
